fg_prog_sequencer: RTL and testbench
====================================

# fg_prog_sequencer

Parametrised programming sequencer for the floating-gate switch matrices of the CAB islands. It replaces static per-island decoder settings with a command-driven engine. It selects one island, row and column through one-hot decoder selects, then drives the drain-select and tunnelling enables with programmable pulse widths and settle times. It also adds an auto-increment scan mode that sweeps consecutive cells.

## Interface
- NUM_ISLANDS, 2, number of islands; island_sel width
- NUM_ROWS, 12, rows per island matrix; row_sel width
- NUM_COLS, 20, columns per island matrix; col_sel width
- PULSE_W, 16, width of pulse-length field
- SETTLE_CYC, 4, settle cycles before and after every pulse (≥1)
- Derived: IB=$clog2(NUM_ISLANDS), RB=$clog2(NUM_ROWS), CB=$clog2(NUM_COLS), NB=$clog2(NUM_ROWS*NUM_COLS+1)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 RUN, 01 PROG, 10 PROG_SCAN, 11 TUNNEL
- cmd_island  in  IB  island index
- cmd_row  in  RB  start row
- cmd_col  in  CB  start column
- cmd_pulse  in  PULSE_W  pulse length in cycles
- cmd_count  in  NB  cells to program (PROG_SCAN only)
- abort  in  1  terminate the current operation
- island_sel  out  NUM_ISLANDS  one-hot island select
- row_sel  out  NUM_ROWS  one-hot row select
- col_sel  out  NUM_COLS  one-hot column select
- prog_mode  out  1  1 = PROG, 0 = RUN
- drain_en  out  1  drain-select pulse
- tun_en  out  1  tunnelling pulse
- busy  out  1  high whenever not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; illegal command, abort or scan overrun

## Operation
- States: IDLE, SETUP, PULSE, RECOVER, NEXT, DONE.
- A command is accepted when cmd_valid && cmd_ready. All fields are registered on acceptance.
- Illegal command: island ≥ NUM_ISLANDS, row ≥ NUM_ROWS, col ≥ NUM_COLS, pulse = 0 (PROG/SCAN/TUNNEL), or count = 0 (SCAN).
  - Go directly to DONE with err=1.
  - No select or enable toggles.
- RUN: go directly to DONE with err=0. All selects and prog_mode are 0.
- PROG and PROG_SCAN:
  - SETUP: island_sel, row_sel, col_sel and prog_mode are asserted for SETTLE_CYC cycles.
  - PULSE: drain_en=1 for exactly cmd_pulse cycles.
  - RECOVER: drain_en=0 for SETTLE_CYC cycles.
- TUNNEL: same sequence as PROG, with these differences:
  - row_sel and col_sel are 0.
  - tun_en replaces drain_en.
- After RECOVER:
  - PROG and TUNNEL go to DONE.
  - PROG_SCAN goes to NEXT if remaining > 1 and the cell is not the last one (row NUM_ROWS−1, col NUM_COLS−1). Otherwise it goes to DONE.
- NEXT (1 cycle): col+1. If col was NUM_COLS−1, col goes to 0 and row+1. remaining−1. Then SETUP.
- Scan overrun: the last cell is finished while remaining > 1. Result is DONE with err=1. Rows never wrap.
- Abort (sampled in SETUP, PULSE, NEXT):
  - drain_en and tun_en go to 0 on the next cycle.
  - Go to RECOVER, then DONE with err=1. No further cells are programmed.
  - Abort seen in RECOVER gives err=1 at DONE.
  - Abort in IDLE or DONE is ignored.
- DONE (1 cycle): done=1. Selects and prog_mode are cleared. Next state is IDLE.
- drain_en and tun_en are never both 1. An enable is never high while selects are changing.

## Timing
- Reset value of all outputs is 0, except cmd_ready, which is 1. Reset takes effect asynchronously, including mid-pulse.
- Outputs are registered. Acceptance edge = cycle 0, S=SETTLE_CYC, P=cmd_pulse.
- PROG / TUNNEL timeline:
  - Selects high in cycles 1..2S+P.
  - Enable high in cycles S+1..S+P.
  - done in cycle 2S+P+1.
  - cmd_ready is 1 again in cycle 2S+P+2.
- PROG_SCAN: each cell takes 2S+P cycles, plus 1 NEXT cycle between cells. done follows the last RECOVER.
- Illegal command and RUN: done in cycle 1.
- busy = !cmd_ready.

## Test plan
- Reset release, then PROG island 1, row 3, col 5, pulse 10 (S=4) -> island_sel=2'b10, row_sel bit 3, col_sel bit 5 in cycles 1–18; drain_en cycles 5–14; done=1, err=0 at cycle 19.
- PROG_SCAN island 0, row 2, col 18, count 3, pulse 2 -> cells (2,18), (2,19), (3,0) programmed in order; each gets a 2-cycle drain_en; done with err=0 after the third RECOVER.
- PROG_SCAN row 11, col 18, count 3 -> only (11,18) and (11,19) programmed; done with err=1; row_sel never wraps.
- Abort asserted in the 3rd PULSE cycle of a pulse-10 PROG -> drain_en=0 the next cycle, 4 RECOVER cycles, then done with err=1.
- TUNNEL island 0, pulse 6 -> tun_en high 6 cycles; row_sel and col_sel stay 0; drain_en stays 0.
- Illegal cases (cmd_island=2, or pulse=0) -> done with err=1 at cycle 1, no enables; async rst asserted mid-PULSE -> all outputs 0 immediately, cmd_ready=1.

Source files
------------

// File: rtl/fg_prog_sequencer.sv
// Command-driven programming sequencer for floating-gate switch matrices.
// Selects one island/row/column cell, then drives a drain or tunnelling pulse framed by settle time.
module fg_prog_sequencer #(
   parameter int unsigned NUM_ISLANDS = 2,
   parameter int unsigned NUM_ROWS    = 12,
   parameter int unsigned NUM_COLS    = 20,
   parameter int unsigned PULSE_W     = 16,
   parameter int unsigned SETTLE_CYC  = 4,
   localparam int unsigned IB = (NUM_ISLANDS > 1) ? $clog2(NUM_ISLANDS) : 1,
   localparam int unsigned RB = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
   localparam int unsigned CB = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
   localparam int unsigned NB = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [IB-1:0]          cmd_island,
   input  logic [RB-1:0]          cmd_row,
   input  logic [CB-1:0]          cmd_col,
   input  logic [PULSE_W-1:0]     cmd_pulse,
   input  logic [NB-1:0]          cmd_count,
   input  logic                   abort,
   output logic [NUM_ISLANDS-1:0] island_sel,
   output logic [NUM_ROWS-1:0]    row_sel,
   output logic [NUM_COLS-1:0]    col_sel,
   output logic                   prog_mode,
   output logic                   drain_en,
   output logic                   tun_en,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam logic [1:0] OpRun    = 2'b00;
   localparam logic [1:0] OpProg   = 2'b01;
   localparam logic [1:0] OpScan   = 2'b10;
   localparam logic [1:0] OpTunnel = 2'b11;

   localparam logic [PULSE_W-1:0] SettleM1 = PULSE_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StPulse,
      StRecover,
      StNext,
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [IB-1:0]        island_q, island_d;
   logic [RB-1:0]        row_q, row_d;
   logic [CB-1:0]        col_q, col_d;
   logic [PULSE_W-1:0]   pulse_q, pulse_d;
   logic [NB-1:0]        rem_q, rem_d;
   logic [PULSE_W-1:0]   timer_q, timer_d;
   logic                 aborted_q, aborted_d;
   logic                 fail_d;

   logic [NUM_ISLANDS-1:0] island_sel_q, island_sel_d;
   logic [NUM_ROWS-1:0]    row_sel_q, row_sel_d;
   logic [NUM_COLS-1:0]    col_sel_q, col_sel_d;
   logic                   prog_mode_q, prog_mode_d;
   logic                   drain_en_q, drain_en_d;
   logic                   tun_en_q, tun_en_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic cmd_illegal;
   logic last_col;
   logic last_cell;
   logic cell_on;
   logic hold_on;

   always_comb begin
      cmd_illegal = (32'(cmd_island) >= NUM_ISLANDS) ||
                    (32'(cmd_row) >= NUM_ROWS) ||
                    (32'(cmd_col) >= NUM_COLS) ||
                    ((cmd_op != OpRun) && (cmd_pulse == '0)) ||
                    ((cmd_op == OpScan) && (cmd_count == '0));
      last_col    = (col_q == CB'(NUM_COLS - 1));
      last_cell   = last_col && (row_q == RB'(NUM_ROWS - 1));
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      island_d  = island_q;
      row_d     = row_q;
      col_d     = col_q;
      pulse_d   = pulse_q;
      rem_d     = rem_q;
      timer_d   = timer_q;
      aborted_d = aborted_q;
      fail_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               op_d      = cmd_op;
               island_d  = cmd_island;
               row_d     = cmd_row;
               col_d     = cmd_col;
               pulse_d   = cmd_pulse;
               rem_d     = cmd_count;
               aborted_d = 1'b0;
               if (cmd_illegal) begin
                  state_d = StDone;
                  fail_d  = 1'b1;
               end else if (cmd_op == OpRun) begin
                  state_d = StDone;
               end else begin
                  state_d = StSetup;
                  timer_d = SettleM1;
               end
            end
         end

         StSetup: begin
            if (abort) begin
               state_d   = StRecover;
               timer_d   = SettleM1;
               aborted_d = 1'b1;
            end else if (timer_q == '0) begin
               state_d = StPulse;
               timer_d = pulse_q - PULSE_W'(1);
            end else begin
               timer_d = timer_q - PULSE_W'(1);
            end
         end

         StPulse: begin
            if (abort) begin
               state_d   = StRecover;
               timer_d   = SettleM1;
               aborted_d = 1'b1;
            end else if (timer_q == '0) begin
               state_d = StRecover;
               timer_d = SettleM1;
            end else begin
               timer_d = timer_q - PULSE_W'(1);
            end
         end

         StRecover: begin
            if (abort) begin
               aborted_d = 1'b1;
            end
            if (timer_q != '0) begin
               timer_d = timer_q - PULSE_W'(1);
            end else if ((op_q == OpScan) && !aborted_d && (rem_q > NB'(1)) && !last_cell) begin
               state_d = StNext;
            end else begin
               // Reaching here with cells still owed means the scan ran off the matrix.
               state_d = StDone;
               fail_d  = aborted_d || ((op_q == OpScan) && (rem_q > NB'(1)));
            end
         end

         StNext: begin
            if (abort) begin
               state_d   = StRecover;
               timer_d   = SettleM1;
               aborted_d = 1'b1;
            end else begin
               state_d = StSetup;
               timer_d = SettleM1;
               rem_d   = rem_q - NB'(1);
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + RB'(1);
               end else begin
                  col_d = col_q + CB'(1);
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_comb begin
      cell_on = state_d inside {StSetup, StPulse, StRecover};
      hold_on = cell_on || (state_d == StNext);

      island_sel_d = '0;
      row_sel_d    = '0;
      col_sel_d    = '0;
      if (hold_on) begin
         island_sel_d = NUM_ISLANDS'(1) << island_d;
      end
      if (cell_on && (op_d != OpTunnel)) begin
         row_sel_d = NUM_ROWS'(1) << row_d;
         col_sel_d = NUM_COLS'(1) << col_d;
      end
      prog_mode_d = hold_on;
      drain_en_d  = (state_d == StPulse) && (op_d != OpTunnel);
      tun_en_d    = (state_d == StPulse) && (op_d == OpTunnel);
      done_d      = (state_d == StDone);
      err_d       = (state_d == StDone) && fail_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         op_q         <= OpRun;
         island_q     <= '0;
         row_q        <= '0;
         col_q        <= '0;
         pulse_q      <= '0;
         rem_q        <= '0;
         timer_q      <= '0;
         aborted_q    <= 1'b0;
         island_sel_q <= '0;
         row_sel_q    <= '0;
         col_sel_q    <= '0;
         prog_mode_q  <= 1'b0;
         drain_en_q   <= 1'b0;
         tun_en_q     <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         island_q     <= island_d;
         row_q        <= row_d;
         col_q        <= col_d;
         pulse_q      <= pulse_d;
         rem_q        <= rem_d;
         timer_q      <= timer_d;
         aborted_q    <= aborted_d;
         island_sel_q <= island_sel_d;
         row_sel_q    <= row_sel_d;
         col_sel_q    <= col_sel_d;
         prog_mode_q  <= prog_mode_d;
         drain_en_q   <= drain_en_d;
         tun_en_q     <= tun_en_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign cmd_ready  = (state_q == StIdle);
   assign busy       = !cmd_ready;
   assign island_sel = island_sel_q;
   assign row_sel    = row_sel_q;
   assign col_sel    = col_sel_q;
   assign prog_mode  = prog_mode_q;
   assign drain_en   = drain_en_q;
   assign tun_en     = tun_en_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: records per-cycle output traces after each
// command and compares selected cycles against hand-computed values (S=4).
module tb_fg_prog_sequencer;

   localparam int TR = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [0:0]  cmd_island;
   logic [3:0]  cmd_row;
   logic [4:0]  cmd_col;
   logic [15:0] cmd_pulse;
   logic [7:0]  cmd_count;
   logic        abort;
   logic [1:0]  island_sel;
   logic [11:0] row_sel;
   logic [19:0] col_sel;
   logic        prog_mode;
   logic        drain_en;
   logic        tun_en;
   logic        busy;
   logic        done;
   logic        err;

   int tests_run = 0;
   int tests_failed = 0;

   logic        drain_tr [0:TR-1];
   logic        tun_tr   [0:TR-1];
   logic        done_tr  [0:TR-1];
   logic        err_tr   [0:TR-1];
   logic        ready_tr [0:TR-1];
   logic        pm_tr    [0:TR-1];
   logic [1:0]  isl_tr   [0:TR-1];
   logic [11:0] row_tr   [0:TR-1];
   logic [19:0] col_tr   [0:TR-1];

   always #5 clk = ~clk;

   fg_prog_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_island (cmd_island),
      .cmd_row    (cmd_row),
      .cmd_col    (cmd_col),
      .cmd_pulse  (cmd_pulse),
      .cmd_count  (cmd_count),
      .abort      (abort),
      .island_sel (island_sel),
      .row_sel    (row_sel),
      .col_sel    (col_sel),
      .prog_mode  (prog_mode),
      .drain_en   (drain_en),
      .tun_en     (tun_en),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int count_drain();
      int n = 0;
      for (int k = 1; k < TR; k++) n += int'(drain_tr[k]);
      return n;
   endfunction

   function automatic int count_tun();
      int n = 0;
      for (int k = 1; k < TR; k++) n += int'(tun_tr[k]);
      return n;
   endfunction

   function automatic int first_done();
      for (int k = 1; k < TR; k++) if (done_tr[k]) return k;
      return 0;
   endfunction

   function automatic int count_rowcol_on();
      int n = 0;
      for (int k = 1; k < TR; k++) if ((row_tr[k] != '0) || (col_tr[k] != '0)) n++;
      return n;
   endfunction

   function automatic int count_row_bad(input logic [11:0] allowed);
      int n = 0;
      for (int k = 1; k < TR; k++) if ((row_tr[k] != '0) && (row_tr[k] != allowed)) n++;
      return n;
   endfunction

   task automatic wait_idle();
      int budget = 200;
      while (!cmd_ready && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      if (budget == 0) check_eq("idle_timeout", 32'(cmd_ready), 32'd1);
   endtask

   // Issue a command on edge 0 and record outputs for cycles 1..ncyc.
   // abort is held high during cycle abort_cyc only (0 = never).
   task automatic run_cmd(input logic [1:0] op, input int isl, input int row, input int col,
                          input int pulse, input int count, input int abort_cyc,
                          input int ncyc);
      for (int k = 0; k < TR; k++) begin
         drain_tr[k] = 0; tun_tr[k] = 0; done_tr[k] = 0; err_tr[k] = 0;
         ready_tr[k] = 0; pm_tr[k] = 0; isl_tr[k] = '0; row_tr[k] = '0; col_tr[k] = '0;
      end
      wait_idle();
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_island = 1'(isl);
      cmd_row    = 4'(row);
      cmd_col    = 5'(col);
      cmd_pulse  = 16'(pulse);
      cmd_count  = 8'(count);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         drain_tr[k] = drain_en;
         tun_tr[k]   = tun_en;
         done_tr[k]  = done;
         err_tr[k]   = err;
         ready_tr[k] = cmd_ready;
         pm_tr[k]    = prog_mode;
         isl_tr[k]   = island_sel;
         row_tr[k]   = row_sel;
         col_tr[k]   = col_sel;
         abort       = (k == abort_cyc);
         @(posedge clk);
         #1;
      end
      abort = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'b00;
      cmd_island = '0;
      cmd_row    = '0;
      cmd_col    = '0;
      cmd_pulse  = '0;
      cmd_count  = '0;
      abort      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(cmd_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_island", 32'(island_sel), 32'd0);
      check_eq("rst_drain", 32'(drain_en), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // PROG island 1, row 3, col 5, pulse 10
      run_cmd(2'b01, 1, 3, 5, 10, 0, 0, 20);
      check_eq("p_isl_c1", 32'(isl_tr[1]), 32'h2);
      check_eq("p_row_c1", 32'(row_tr[1]), 32'h008);
      check_eq("p_col_c1", 32'(col_tr[1]), 32'h00020);
      check_eq("p_pm_c1", 32'(pm_tr[1]), 32'd1);
      check_eq("p_drain_c4", 32'(drain_tr[4]), 32'd0);
      check_eq("p_drain_c5", 32'(drain_tr[5]), 32'd1);
      check_eq("p_drain_c14", 32'(drain_tr[14]), 32'd1);
      check_eq("p_drain_c15", 32'(drain_tr[15]), 32'd0);
      check_eq("p_row_c18", 32'(row_tr[18]), 32'h008);
      check_eq("p_drain_cnt", 32'(count_drain()), 32'd10);
      check_eq("p_done_cyc", 32'(first_done()), 32'd19);
      check_eq("p_err_c19", 32'(err_tr[19]), 32'd0);
      check_eq("p_isl_c19", 32'(isl_tr[19]), 32'd0);
      check_eq("p_ready_c19", 32'(ready_tr[19]), 32'd0);
      check_eq("p_ready_c20", 32'(ready_tr[20]), 32'd1);

      // PROG_SCAN island 0, (2,18), count 3, pulse 2: cells at 1..10, 12..21, 23..32
      run_cmd(2'b10, 0, 2, 18, 2, 3, 0, 34);
      check_eq("s_col_c5", 32'(col_tr[5]), 32'h40000);
      check_eq("s_row_c5", 32'(row_tr[5]), 32'h004);
      check_eq("s_col_c16", 32'(col_tr[16]), 32'h80000);
      check_eq("s_row_c16", 32'(row_tr[16]), 32'h004);
      check_eq("s_col_c27", 32'(col_tr[27]), 32'h00001);
      check_eq("s_row_c27", 32'(row_tr[27]), 32'h008);
      check_eq("s_drain_c27", 32'(drain_tr[27]), 32'd1);
      check_eq("s_drain_cnt", 32'(count_drain()), 32'd6);
      check_eq("s_done_cyc", 32'(first_done()), 32'd33);
      check_eq("s_err", 32'(err_tr[33]), 32'd0);

      // PROG_SCAN from (11,18), count 3: overrun after (11,19)
      run_cmd(2'b10, 0, 11, 18, 2, 3, 0, 24);
      check_eq("o_col_c16", 32'(col_tr[16]), 32'h80000);
      check_eq("o_row_c16", 32'(row_tr[16]), 32'h800);
      check_eq("o_drain_cnt", 32'(count_drain()), 32'd4);
      check_eq("o_done_cyc", 32'(first_done()), 32'd22);
      check_eq("o_err", 32'(err_tr[22]), 32'd1);
      check_eq("o_row_wrap", 32'(count_row_bad(12'h800)), 32'd0);

      // Abort during the 3rd pulse cycle (cycle 7) of a pulse-10 PROG
      run_cmd(2'b01, 0, 0, 0, 10, 0, 7, 14);
      check_eq("a_drain_c7", 32'(drain_tr[7]), 32'd1);
      check_eq("a_drain_c8", 32'(drain_tr[8]), 32'd0);
      check_eq("a_pm_c11", 32'(pm_tr[11]), 32'd1);
      check_eq("a_row_c11", 32'(row_tr[11]), 32'h001);
      check_eq("a_drain_cnt", 32'(count_drain()), 32'd3);
      check_eq("a_done_cyc", 32'(first_done()), 32'd12);
      check_eq("a_err", 32'(err_tr[12]), 32'd1);

      // TUNNEL island 0, pulse 6
      run_cmd(2'b11, 0, 1, 1, 6, 0, 0, 17);
      check_eq("t_tun_cnt", 32'(count_tun()), 32'd6);
      check_eq("t_tun_c5", 32'(tun_tr[5]), 32'd1);
      check_eq("t_tun_c10", 32'(tun_tr[10]), 32'd1);
      check_eq("t_tun_c11", 32'(tun_tr[11]), 32'd0);
      check_eq("t_drain_cnt", 32'(count_drain()), 32'd0);
      check_eq("t_rowcol", 32'(count_rowcol_on()), 32'd0);
      check_eq("t_isl_c1", 32'(isl_tr[1]), 32'h1);
      check_eq("t_done_cyc", 32'(first_done()), 32'd15);
      check_eq("t_err", 32'(err_tr[15]), 32'd0);

      // Illegal commands and RUN
      run_cmd(2'b01, 0, 12, 0, 5, 0, 0, 4);
      check_eq("i_row_done", 32'(first_done()), 32'd1);
      check_eq("i_row_err", 32'(err_tr[1]), 32'd1);
      check_eq("i_row_isl", 32'(isl_tr[1]), 32'd0);
      check_eq("i_row_drain", 32'(count_drain()), 32'd0);
      run_cmd(2'b01, 1, 0, 20, 5, 0, 0, 4);
      check_eq("i_col_err", 32'(err_tr[1]), 32'd1);
      run_cmd(2'b01, 0, 0, 0, 0, 0, 0, 4);
      check_eq("i_pulse_done", 32'(first_done()), 32'd1);
      check_eq("i_pulse_err", 32'(err_tr[1]), 32'd1);
      run_cmd(2'b10, 0, 0, 0, 3, 0, 0, 4);
      check_eq("i_count_err", 32'(err_tr[1]), 32'd1);
      check_eq("i_count_drain", 32'(count_drain()), 32'd0);
      run_cmd(2'b00, 1, 3, 5, 0, 0, 0, 4);
      check_eq("run_done", 32'(first_done()), 32'd1);
      check_eq("run_err", 32'(err_tr[1]), 32'd0);
      check_eq("run_pm", 32'(pm_tr[1]), 32'd0);
      check_eq("run_ready_c2", 32'(ready_tr[2]), 32'd1);

      // Async reset mid-pulse: now in cycle 7 of a pulse-10 PROG
      run_cmd(2'b01, 1, 2, 2, 10, 0, 0, 6);
      check_eq("r_pre_drain", 32'(drain_en), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("r_drain", 32'(drain_en), 32'd0);
      check_eq("r_isl", 32'(island_sel), 32'd0);
      check_eq("r_row", 32'(row_sel), 32'd0);
      check_eq("r_pm", 32'(prog_mode), 32'd0);
      check_eq("r_ready", 32'(cmd_ready), 32'd1);
      check_eq("r_busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_cmd(2'b00, 0, 0, 0, 0, 0, 0, 2);
      check_eq("r_run_done", 32'(first_done()), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
